// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
// Holds the divider state encoding, the default operand width and a
// helper that sizes iteration counters.
package arith_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Bits needed to count 0..w-1; never less than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/addsub_w.sv
// Combinational W-bit adder/subtractor.
// Ports:
//   i_a, i_b  operands
//   i_sub     0 = add, 1 = subtract (a - b)
//   o_sum     W-bit result
//   o_cout    carry out; in subtract mode 1 means no borrow (a >= b)
module addsub_w #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W-1:0] w_b_eff;
  logic [W:0]   w_full;

  // Two's-complement subtract: a + ~b + 1.
  assign w_b_eff = i_sub ? ~i_b : i_b;
  assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{W{1'b0}}, i_sub};
  assign o_sum   = w_full[W-1:0];
  assign o_cout  = w_full[W];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// state   | meaning
// --------|---------------------------------------------
// ST_IDLE | waiting for i_start; results held
// ST_RUN  | WIDTH trial-subtract iterations in progress
//
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_start                 request, sampled only in ST_IDLE
//   i_dividend, i_divisor   operands, captured on the accepting edge
//   o_busy                  operation in progress
//   o_done                  one-cycle strobe, results valid
//   o_quotient, o_remainder results, held until the next o_done
//   o_div_zero              completed operation had a zero divisor
import arith_pkg::*;

module seq_divider #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_zero
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;

  logic [WIDTH:0]   w_trial_a;
  logic [WIDTH:0]   w_trial_b;
  logic [WIDTH:0]   w_t;
  logic             w_no_borrow;
  logic [WIDTH:0]   w_r_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // Shift partial remainder left, bringing in the next dividend bit.
  // The top bit of R is always zero here, so it simply shifts out.
  assign w_trial_a = (r_r << 1) | {{WIDTH{1'b0}}, r_q[WIDTH-1]};
  assign w_trial_b = {1'b0, r_d};

  addsub_w #(.W(WIDTH + 1)) u_trial_sub (
    .i_a    (w_trial_a),
    .i_b    (w_trial_b),
    .i_sub  (1'b1),
    .o_sum  (w_t),
    .o_cout (w_no_borrow)
  );

  assign w_r_nxt = w_no_borrow ? w_t : w_trial_a;
  assign w_q_nxt = {r_q[WIDTH-2:0], w_no_borrow};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q    <= '0;
      r_d    <= '0;
      r_r    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_q    <= i_dividend;
        r_d    <= i_divisor;
        r_r    <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_state == ST_RUN) begin
        r_r   <= w_r_nxt;
        r_q   <= w_q_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_quot <= w_q_nxt;
          r_rem  <= w_r_nxt[WIDTH-1:0];
          r_dz   <= (r_d == '0);
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_quotient  = r_quot;
  assign o_remainder = r_rem;
  assign o_div_zero  = r_dz;

endmodule
